// File: rtl/pa_pkg.sv
// Shared constants and types for the pa pipeline writeback slice.
// Optional macro PA_ZERO_REG_EN makes register 0 a hardwired zero.
package pa_pkg;

  localparam int PA_DATA_W = 32;
  localparam int PA_ADDR_W = 5;
  localparam int PA_NUM_RD = 2;
  localparam int PA_CNT_W  = 32;

  localparam int PA_RD_ADDR_W = PA_NUM_RD * PA_ADDR_W;
  localparam int PA_RD_DATA_W = PA_NUM_RD * PA_DATA_W;

  typedef logic [PA_ADDR_W-1:0] reg_addr_t;
  typedef logic [PA_DATA_W-1:0] data_t;

endpackage

// File: rtl/pa_rf_array.sv
// Register file storage: one write port, NUM_RD combinational reads.
// With PA_ZERO_REG_EN, entry 0 is never written and always reads 0.
module pa_rf_array
  import pa_pkg::*;
#(
  parameter int DATA_W = PA_DATA_W,
  parameter int ADDR_W = PA_ADDR_W,
  parameter int NUM_RD = PA_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              we_eff;

`ifdef PA_ZERO_REG_EN
  assign we_eff = we && (waddr != '0);
`else
  assign we_eff = we;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we_eff) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[g*ADDR_W +: ADDR_W];
`ifdef PA_ZERO_REG_EN
    assign rdata[g*DATA_W +: DATA_W] = (ra == '0) ? '0 : mem[ra];
`else
    assign rdata[g*DATA_W +: DATA_W] = mem[ra];
`endif
  end

endmodule

// File: rtl/pa_writeback_rf.sv
// Writeback stage: one-entry staging register, regfile, forwarding reads.
// Macro PA_ZERO_REG_EN: register 0 reads zero, no forwarding for addr 0.
module pa_writeback_rf
  import pa_pkg::*;
#(
  parameter int DATA_W = PA_DATA_W,
  parameter int ADDR_W = PA_ADDR_W,
  parameter int NUM_RD = PA_NUM_RD,
  parameter int CNT_W  = PA_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     commit_stall,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     commit_valid,
  output logic [ADDR_W-1:0]        commit_addr,
  output logic [CNT_W-1:0]         commit_count
);

  logic              s_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic              commit;
  logic              xfer;
  logic [NUM_RD*DATA_W-1:0] rf_rdata;

  assign wb_ready = !s_valid || !commit_stall;
  assign commit   = s_valid && !commit_stall;
  assign xfer     = wb_valid && wb_ready;

  // Transfer and commit may share an edge: old entry retires, new one lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid <= 1'b0;
      s_addr  <= '0;
      s_data  <= '0;
    end else if (xfer) begin
      s_valid <= 1'b1;
      s_addr  <= wb_addr;
      s_data  <= wb_data;
    end else if (commit) begin
      s_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid <= 1'b0;
      commit_addr  <= '0;
      commit_count <= '0;
    end else begin
      commit_valid <= commit;
      if (commit) begin
        commit_addr  <= s_addr;
        commit_count <= commit_count + CNT_W'(1);
      end
    end
  end

  pa_rf_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit),
    .waddr (s_addr),
    .wdata (s_data),
    .raddr (rd_addr),
    .rdata (rf_rdata)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_fwd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    assign ra = rd_addr[g*ADDR_W +: ADDR_W];
`ifdef PA_ZERO_REG_EN
    assign hit = s_valid && (s_addr == ra) && (ra != '0);
`else
    assign hit = s_valid && (s_addr == ra);
`endif
    assign rd_data[g*DATA_W +: DATA_W] =
      hit ? s_data : rf_rdata[g*DATA_W +: DATA_W];
  end

endmodule

// File: tb/tb_pa_writeback_rf.sv
// Directed bench for pa_writeback_rf with a commit scoreboard.
// Honours PA_ZERO_REG_EN for the register-0 expectations.
module tb_pa_writeback_rf;
  import pa_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    wb_valid;
  logic                    wb_ready;
  logic [PA_ADDR_W-1:0]    wb_addr;
  logic [PA_DATA_W-1:0]    wb_data;
  logic                    commit_stall;
  logic [PA_RD_ADDR_W-1:0] rd_addr;
  logic [PA_RD_DATA_W-1:0] rd_data;
  logic                    commit_valid;
  logic [PA_ADDR_W-1:0]    commit_addr;
  logic [PA_CNT_W-1:0]     commit_count;

  typedef struct {
    logic [PA_ADDR_W-1:0] addr;
    logic [PA_CNT_W-1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  pa_writeback_rf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .commit_stall (commit_stall),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr),
    .commit_count (commit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(int p);
    return rd_data[p*PA_DATA_W +: PA_DATA_W];
  endfunction

  task automatic set_rd(int a0, int a1);
    rd_addr = {PA_ADDR_W'(a1), PA_ADDR_W'(a0)};
  endtask

  task automatic push(int a);
    exp_t e;
    exp_cnt++;
    e.addr = PA_ADDR_W'(a);
    e.cnt  = PA_CNT_W'(exp_cnt);
    exp_q.push_back(e);
  endtask

  task automatic drive(int a, logic [31:0] d);
    wb_valid = 1'b1;
    wb_addr  = PA_ADDR_W'(a);
    wb_data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every commit pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst_n && commit_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: addr %0d cnt %0d",
                 commit_addr, commit_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_addr", 64'(commit_addr), 64'(e.addr));
        chk("commit_count", 64'(commit_count), 64'(e.cnt));
      end
    end
  end

  initial begin
    logic [31:0] z0;
`ifdef PA_ZERO_REG_EN
    z0 = 32'h0;
`else
    z0 = 32'h1234;
`endif
    rst_n = 1'b0;
    wb_valid = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    commit_stall = 1'b0;
    set_rd(0, 0);
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(wb_ready), 64'd1);
    chk("rst_count", 64'(commit_count), 64'd0);
    chk("rst_cvalid", 64'(commit_valid), 64'd0);
    chk("rst_rd0", 64'(rd(0)), 64'd0);

    // Stage addr 3 under stall, then reset discards it.
    step();
    commit_stall = 1'b1;
    drive(3, 32'hAA);
    set_rd(3, 3);
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("stage3_fwd", 64'(rd(0)), 64'hAA);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    commit_stall = 1'b0;
    @(negedge clk);
    chk("mid_rst_rd0", 64'(rd(0)), 64'd0);
    chk("mid_rst_rd1", 64'(rd(1)), 64'd0);
    chk("mid_rst_count", 64'(commit_count), 64'd0);
    chk("mid_rst_cvalid", 64'(commit_valid), 64'd0);
    step();
    @(negedge clk);
    chk("mid_rst_reg3", 64'(rd(0)), 64'd0);

    // Single write with forwarding then regfile read.
    step();
    set_rd(7, 0);
    drive(7, 32'hDEADBEEF);
    push(7);
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("w7_fwd", 64'(rd(0)), 64'hDEADBEEF);
    chk("w7_cvalid0", 64'(commit_valid), 64'd0);
    step();
    @(negedge clk);
    chk("w7_rf", 64'(rd(0)), 64'hDEADBEEF);
    chk("w7_cvalid1", 64'(commit_valid), 64'd1);
    chk("w7_count", 64'(commit_count), 64'd1);

    // Back-to-back writes to addr 4.
    step();
    for (int i = 1; i <= 3; i++) begin
      drive(4, 32'(i));
      push(4);
      chk("b2b_ready", 64'(wb_ready), 64'd1);
      step();
    end
    wb_valid = 1'b0;
    set_rd(4, 4);
    repeat (2) step();
    @(negedge clk);
    chk("b2b_reg4", 64'(rd(0)), 64'd3);
    chk("b2b_count", 64'(commit_count), 64'd4);

    // Stall with a second request waiting.
    step();
    commit_stall = 1'b1;
    drive(2, 32'h55);
    push(2);
    set_rd(2, 9);
    step();
    drive(9, 32'h66);
    push(9);
    @(negedge clk);
    chk("stall_ready", 64'(wb_ready), 64'd0);
    chk("stall_fwd2", 64'(rd(0)), 64'h55);
    chk("stall_reg9", 64'(rd(1)), 64'h0);
    step();
    @(negedge clk);
    chk("stall_ready2", 64'(wb_ready), 64'd0);
    chk("stall_cvalid", 64'(commit_valid), 64'd0);
    chk("stall_count", 64'(commit_count), 64'd4);
    step();
    commit_stall = 1'b0;
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("unst_reg2", 64'(rd(0)), 64'h55);
    chk("unst_fwd9", 64'(rd(1)), 64'h66);
    step();
    @(negedge clk);
    chk("unst_reg9", 64'(rd(1)), 64'h66);
    chk("unst_count", 64'(commit_count), 64'd6);

    // Two ports on addr 5 while an older write to 5 commits.
    step();
    set_rd(5, 5);
    drive(5, 32'h11);
    push(5);
    step();
    drive(5, 32'h22);
    push(5);
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("dup_p0", 64'(rd(0)), 64'h22);
    chk("dup_p1", 64'(rd(1)), 64'h22);
    step();
    @(negedge clk);
    chk("dup_rf_p0", 64'(rd(0)), 64'h22);
    chk("dup_rf_p1", 64'(rd(1)), 64'h22);

    // Register 0 write.
    step();
    set_rd(0, 0);
    drive(0, 32'h1234);
    push(0);
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("z_fwd_p0", 64'(rd(0)), 64'(z0));
    chk("z_fwd_p1", 64'(rd(1)), 64'(z0));
    step();
    @(negedge clk);
    chk("z_rf_p0", 64'(rd(0)), 64'(z0));
    chk("z_rf_p1", 64'(rd(1)), 64'(z0));
    chk("z_count", 64'(commit_count), 64'd9);

    repeat (3) step();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pa_writeback_rf.md
Name: pa_writeback_rf

Overview:
- Parametrised writeback stage with its own register file, the next generation of the simple writeback block.
- Adds:
  - a valid/ready handshake
  - a one-entry staging register with commit stall
  - N combinational read ports with forwarding from the staged entry
  - reset of all state
  - a commit counter
- Sits at the end of the pa pipeline. It receives ALU results from execute and serves operand reads back to decode.

Parameters:
- DATA_W, 32, register/data width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (>=1)
- CNT_W, 32, commit counter width

Ports:
- clk  in  1  sole clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  writeback request present
- wb_ready  out  1  stage can accept a request this cycle
- wb_addr  in  ADDR_W  destination register
- wb_data  in  DATA_W  value to write
- commit_stall  in  1  blocks the staged entry from committing
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
- commit_valid  out  1  registered pulse: a commit happened on the previous edge
- commit_addr  out  ADDR_W  address of that commit
- commit_count  out  CNT_W  total commits since reset

Behaviour:
- Reset (async assert, sync release on clk): all DEPTH registers = 0; s_valid = 0; s_addr = 0; s_data = 0; commit_valid = 0; commit_addr = 0; commit_count = 0.
  - Asserting rst_n low mid-operation discards any staged entry. No commit occurs for it.
- Handshake:
  - wb_ready = !s_valid || !commit_stall (combinational).
  - A transfer happens when wb_valid && wb_ready at posedge. wb_addr and wb_data are captured into the staging register (S) and s_valid is set to 1.
  - wb_valid low with nothing committing leaves S unchanged.
- Commit, at each posedge when s_valid && !commit_stall:
  - regfile[s_addr] <= s_data
  - commit_count <= commit_count + 1 (wraps modulo 2**CNT_W)
  - commit_valid <= 1 and commit_addr <= s_addr
  - Otherwise commit_valid <= 0 and commit_addr holds.
- Simultaneous commit and transfer on the same edge: the old entry commits and S is loaded with the new entry; s_valid stays 1. This gives full throughput of 1 write/cycle when unstalled.
- Commit without transfer: s_valid <= 0.
- Stall with s_valid = 1: S holds, wb_ready = 0, no commit.
- Latency:
  - A request transferred at edge N is readable via forwarding from just after edge N.
  - It is in the regfile after the first unstalled edge after N, i.e. N+1 with no stall.
- Read ports (combinational, each independent):
  - rd_data[i] = (s_valid && s_addr == rd_addr[i]) ? s_data : regfile[rd_addr[i]].
  - Any port may read any address, including duplicates.
- Same-address back-to-back writes: program order is preserved; the later write wins in both forwarding and final regfile contents.
- No X propagation: all addresses are in range by construction (DEPTH = 2**ADDR_W).

Optional Feature:
- Macro: PA_ZERO_REG_EN
- Defined:
  - Register 0 reads constant 0 on every port.
  - Writes to address 0 are still accepted, staged, and committed: they count in commit_count and pulse commit_valid with commit_addr = 0.
  - regfile[0] is never written, and forwarding is suppressed when the address is 0.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package pa_pkg:
  - default constants PA_DATA_W = 32 and PA_ADDR_W = 5
  - typedefs for reg address and data words
  - the read-port packing helper width constants
- One natural sub-module, pa_rf_array:
  - DEPTH x DATA_W storage, reset logic, single write port, NUM_RD read muxes
  - The staging, forwarding and counter logic lives in the top.

Test Plan:
- Reset with rst_n = 0 mid-stream (S holding addr 3, data 0xAA) -> after release all rd_data = 0, commit_count = 0, commit_valid = 0, and reg 3 reads 0.
- Write addr 7 = 0xDEADBEEF at edge N, rd_addr0 = 7 -> rd_data0 = 0xDEADBEEF after edge N (forwarded) and still after edge N+1 (from the regfile); commit_valid = 1 after N+1 and commit_count = 1.
- Back-to-back writes addr 4 = 1, 2, 3 on three consecutive cycles, no stall -> wb_ready stays 1, final reg 4 = 3, and commit_count increments by 3.
- Assert commit_stall with S holding addr 2 = 0x55 and wb_valid held with addr 9 = 0x66 -> wb_ready = 0 and reg 2 is not written. After the stall drops, reg 2 = 0x55 then reg 9 = 0x66 on consecutive edges.
- Two ports reading the same staged address 5 while a new write to 5 commits -> both ports return the newest staged value.
- With PA_ZERO_REG_EN defined, write addr 0 = 0x1234 -> rd_data = 0 on all ports, commit_count increments, and commit_addr = 0. Without the macro, the same stimulus reads back 0x1234.
